// File: rtl/apb_slave_mem_pkg.sv
// Shared APB environment package: phase encoding, slave memory defaults and
// the latched SETUP-phase decode record.
package apb_slave_mem_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ACCESS = 2'd2
  } operation_states_e;

  localparam int unsigned SLAVE_MEM_DEPTH   = 16;
  localparam int unsigned SLAVE_WAIT_STATES = 1;
  localparam int unsigned SLAVE_IDX_W       = 32;

  typedef struct packed {
    logic [SLAVE_IDX_W-1:0] index;
    logic                   write;
    logic                   err;
  } apb_slave_req_s;

endpackage

// File: rtl/apb_slave_mem_array.sv
// DEPTH x DATA_WIDTH register storage with byte-lane write enables,
// combinational read port and asynchronous clear.
module apb_slave_mem_array
  import apb_slave_mem_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 64,
  parameter int unsigned DEPTH      = SLAVE_MEM_DEPTH
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    we,
  input  logic [SLAVE_IDX_W-1:0]  widx,
  input  logic [DATA_WIDTH/8-1:0] wstrb,
  input  logic [DATA_WIDTH-1:0]   wdata,
  input  logic [SLAVE_IDX_W-1:0]  ridx,
  output logic [DATA_WIDTH-1:0]   rdata
);

  localparam int unsigned STRB_W = DATA_WIDTH / 8;
  localparam int unsigned IDX_W  = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];
  logic [DATA_WIDTH-1:0] mem_d [DEPTH];
  logic                  widx_ok;
  logic                  ridx_ok;

  // Bounds guards keep non-power-of-two depths from aliasing onto real words.
  assign widx_ok = widx < SLAVE_IDX_W'(DEPTH);
  assign ridx_ok = ridx < SLAVE_IDX_W'(DEPTH);

  always_comb begin
    mem_d = mem_q;
    if (we && widx_ok) begin
      for (int i = 0; i < STRB_W; i++) begin
        if (wstrb[i]) begin
          mem_d[IDX_W'(widx)][i*8 +: 8] = wdata[i*8 +: 8];
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      mem_q <= mem_d;
    end
  end

  assign rdata = ridx_ok ? mem_q[IDX_W'(ridx)] : '0;

endmodule

// File: rtl/apb_slave_mem.sv
// APB slave register-file target: IDLE/SETUP/ACCESS phase tracking, fixed
// wait-state insertion, byte-strobed writes and error-flagged decode.
module apb_slave_mem
  import apb_slave_mem_pkg::*;
#(
  parameter int unsigned              ADDRESS_LENGTH = 32,
  parameter int unsigned              DATA_WIDTH     = 64,
  parameter int unsigned              DEPTH          = SLAVE_MEM_DEPTH,
  parameter logic [ADDRESS_LENGTH-1:0] BASE_ADDR     = '0,
  parameter int unsigned              WAIT_STATES    = SLAVE_WAIT_STATES
) (
  input  logic                      pclk,
  input  logic                      preset_n,
  input  logic                      psel,
  input  logic                      penable,
  input  logic                      pwrite,
  input  logic [ADDRESS_LENGTH-1:0] paddr,
  input  logic [DATA_WIDTH-1:0]     pwdata,
  input  logic [DATA_WIDTH/8-1:0]   pstrb,
  output logic                      pready,
  output logic [DATA_WIDTH-1:0]     prdata,
  output logic                      pslverr
);

  localparam int unsigned STRB_W   = DATA_WIDTH / 8;
  localparam int unsigned OFF_BITS = $clog2(STRB_W);

  operation_states_e         state_q, state_d;
  logic [2:0]                cnt_q, cnt_d;
  apb_slave_req_s            req_q, req_d;
  logic [ADDRESS_LENGTH-1:0] offset;
  logic [ADDRESS_LENGTH-1:0] word_idx;
  logic                      misaligned;
  logic                      out_of_range;
  logic                      mem_we;
  logic [DATA_WIDTH-1:0]     mem_rdata;

  // Offset wraps on underflow, so addresses below BASE_ADDR land out of range.
  always_comb begin
    offset       = paddr - BASE_ADDR;
    word_idx     = offset >> OFF_BITS;
    misaligned   = (offset & ADDRESS_LENGTH'(STRB_W - 1)) != '0;
    out_of_range = word_idx >= ADDRESS_LENGTH'(DEPTH);
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    req_d   = req_q;
    case (state_q)
      IDLE: begin
        if (psel && !penable) state_d = SETUP;
      end
      SETUP: begin
        state_d     = ACCESS;
        cnt_d       = 3'(WAIT_STATES);
        req_d.index = SLAVE_IDX_W'(word_idx);
        req_d.write = pwrite;
        req_d.err   = misaligned || out_of_range;
      end
      ACCESS: begin
        if (!psel) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else if (cnt_q != 3'd0) begin
          cnt_d = cnt_q - 3'd1;
        end else if (!penable) begin
          state_d = SETUP;
        end else begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge pclk or negedge preset_n) begin
    if (!preset_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      req_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      req_q   <= req_d;
    end
  end

  assign pready  = (state_q == ACCESS) && (cnt_q == 3'd0);
  assign mem_we  = pready && psel && req_q.write && !req_q.err;
  assign pslverr = pready && req_q.err;
  assign prdata  = (pready && !req_q.write && !req_q.err) ? mem_rdata : '0;

  apb_slave_mem_array #(
    .DATA_WIDTH(DATA_WIDTH),
    .DEPTH     (DEPTH)
  ) u_array (
    .clk  (pclk),
    .rst_n(preset_n),
    .we   (mem_we),
    .widx (req_q.index),
    .wstrb(pstrb),
    .wdata(pwdata),
    .ridx (req_q.index),
    .rdata(mem_rdata)
  );

endmodule
